cbus_rr_arbiter: RTL and testbench

//  Round-robin arbiter that merges NUM_INPUTS cbus masters (I$ refill, uncached I-fetch, D$ refill/writeback,

---
 rtl/cbus_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter merging several cbus masters onto one downstream cbus port.
// Grants whole transactions and steers the downstream response back to the granted master only.
package cbus_pkg;
   localparam logic [3:0] MSIZE1 = 4'd0;
   localparam logic [3:0] MSIZE2 = 4'd1;
   localparam logic [3:0] MSIZE4 = 4'd3;
   localparam logic [3:0] MSIZE8 = 4'd7;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        okay;
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_INPUTS = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  ireqs  [NUM_INPUTS],
   output cbus_resp_t iresps [NUM_INPUTS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e           state_r;
   state_e           state_nxt_s;
   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] sel_nxt_s;
   logic [SEL_W-1:0] rr_ptr_r;
   logic [SEL_W-1:0] rr_ptr_nxt_s;
   logic [SEL_W-1:0] winner_s;
   logic [SEL_W-1:0] sel_inc_s;
   logic             found_s;

   // Scan masters starting at the round-robin pointer; first valid one wins
   always_comb begin
      logic [SEL_W:0] cand_v;
      found_s  = 1'b0;
      winner_s = '0;
      cand_v   = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         cand_v = {1'b0, rr_ptr_r} + (SEL_W+1)'(k);
         if (cand_v >= (SEL_W+1)'(NUM_INPUTS)) begin
            cand_v = cand_v - (SEL_W+1)'(NUM_INPUTS);
         end else begin
            cand_v = cand_v;
         end
         if (!found_s && ireqs[cand_v[SEL_W-1:0]].valid) begin
            found_s  = 1'b1;
            winner_s = cand_v[SEL_W-1:0];
         end else begin
            found_s  = found_s;
            winner_s = winner_s;
         end
      end
   end

   // Pointer value after the current grant, wrapping at the last master
   always_comb begin
      if (sel_r == SEL_W'(NUM_INPUTS - 1)) begin
         sel_inc_s = '0;
      end else begin
         sel_inc_s = sel_r + SEL_W'(1);
      end
   end

   // Next-state logic: a transaction ends on the last ready beat or when the master withdraws
   always_comb begin
      state_nxt_s  = state_r;
      sel_nxt_s    = sel_r;
      rr_ptr_nxt_s = rr_ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_nxt_s = ST_BUSY;
               sel_nxt_s   = winner_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!ireqs[sel_r].valid || (oresp.ready && oresp.last)) begin
               state_nxt_s  = ST_IDLE;
               rr_ptr_nxt_s = sel_inc_s;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output steering: pass-through only while busy, response only to a still-requesting master
   always_comb begin
      oreq = '0;
      for (int j = 0; j < NUM_INPUTS; j++) begin
         iresps[j] = '0;
      end
      if (state_r == ST_BUSY) begin
         oreq = ireqs[sel_r];
         if (ireqs[sel_r].valid) begin
            iresps[sel_r] = oresp;
         end else begin
            iresps[sel_r] = '0;
         end
      end else begin
         oreq = '0;
      end
   end

   // State, grant index and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r  <= ST_IDLE;
         sel_r    <= '0;
         rr_ptr_r <= '0;
      end else begin
         state_r  <= state_nxt_s;
         sel_r    <= sel_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: table-driven grant sequence, directed corner cases,
// and randomized traffic checked against a priority-ranking reference model.
module tb_cbus_rr_arbiter;
   import cbus_pkg::*;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       resetn;
   cbus_req_t  ireqs_d  [N];
   cbus_resp_t iresps_s [N];
   cbus_req_t  oreq_s;
   cbus_resp_t oresp_d;

   int vec_cnt = 0;
   int err_cnt = 0;

   // reference model state
   int m_busy = 0;
   int m_sel  = 0;
   int m_ptr  = 0;

   typedef struct {
      logic           rstn;
      logic [N-1:0]   vld;
      logic           rdy;
      logic           lst;
      int             exp;
   } vec_t;

   vec_t tbl [13];

   always #5 clk = ~clk;

   cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
      .clk   (clk),
      .resetn(resetn),
      .ireqs (ireqs_d),
      .iresps(iresps_s),
      .oreq  (oreq_s),
      .oresp (oresp_d)
   );

   task automatic drive(input logic rstn, input logic [N-1:0] vld, input logic rdy, input logic lst);
      resetn = rstn;
      for (int i = 0; i < N; i++) begin
         ireqs_d[i].valid    = vld[i];
         ireqs_d[i].is_write = 1'($urandom_range(0, 1));
         ireqs_d[i].size     = 3'($urandom_range(0, 7));
         ireqs_d[i].addr     = 32'h1000_0000 + (32'(i) << 8) + 32'($urandom_range(0, 255));
         ireqs_d[i].strobe   = 4'($urandom_range(0, 15));
         ireqs_d[i].data     = $urandom;
         ireqs_d[i].len      = MSIZE4;
      end
      oresp_d.okay  = 1'($urandom_range(0, 1));
      oresp_d.ready = rdy;
      oresp_d.last  = lst;
      oresp_d.data  = $urandom;
   endtask

   // exp < 0: arbiter idle, every output zero; otherwise master exp is granted
   task automatic check(input string name, input int exp);
      cbus_req_t  er;
      cbus_resp_t ers;
      logic       bad;
      bad = 1'b0;
      if (exp < 0) er = '0;
      else         er = ireqs_d[exp];
      if (oreq_s !== er) begin
         bad = 1'b1;
         $display("FAIL %s oreq: got %h want %h", name, oreq_s, er);
      end
      for (int j = 0; j < N; j++) begin
         if (exp == j && ireqs_d[j].valid) ers = oresp_d;
         else                              ers = '0;
         if (iresps_s[j] !== ers) begin
            bad = 1'b1;
            $display("FAIL %s iresps[%0d]: got %h want %h", name, j, iresps_s[j], ers);
         end
      end
      vec_cnt++;
      if (bad) err_cnt++;
   endtask

   task automatic step(input logic rstn, input logic [N-1:0] vld, input logic rdy, input logic lst,
                       input int exp, input string name);
      @(posedge clk);
      #1;
      drive(rstn, vld, rdy, lst);
      @(negedge clk);
      check(name, exp);
   endtask

   task automatic check_val(input string name, input int got, input int want);
      vec_cnt++;
      if (got != want) begin
         err_cnt++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Reference: lowest rank (distance from the pointer) among requesters wins
   task automatic model_update(input logic rstn, input logic [N-1:0] vld, input logic rdy, input logic lst);
      int best;
      int best_rank;
      if (!rstn) begin
         m_busy = 0; m_sel = 0; m_ptr = 0;
      end else if (m_busy == 0) begin
         best = -1; best_rank = N;
         for (int i = 0; i < N; i++) begin
            if (vld[i] && ((i - m_ptr + N) % N) < best_rank) begin
               best_rank = (i - m_ptr + N) % N;
               best      = i;
            end
         end
         if (best >= 0) begin
            m_busy = 1; m_sel = best;
         end
      end else if (!vld[m_sel] || (rdy && lst)) begin
         m_busy = 0;
         m_ptr  = (m_sel + 1) % N;
      end
   endtask

   initial begin
      int rdy_cnt;
      int lst_cnt;

      // reset, then all four requesting with 1-beat transactions
      tbl[0]  = '{1'b0, 4'hF, 1'b1, 1'b1, -1};
      tbl[1]  = '{1'b0, 4'hF, 1'b1, 1'b1, -1};
      tbl[2]  = '{1'b1, 4'hF, 1'b1, 1'b1, -1};
      tbl[3]  = '{1'b1, 4'hF, 1'b1, 1'b1,  0};
      tbl[4]  = '{1'b1, 4'hF, 1'b1, 1'b1, -1};
      tbl[5]  = '{1'b1, 4'hF, 1'b1, 1'b1,  1};
      tbl[6]  = '{1'b1, 4'hF, 1'b1, 1'b1, -1};
      tbl[7]  = '{1'b1, 4'hF, 1'b1, 1'b1,  2};
      tbl[8]  = '{1'b1, 4'hF, 1'b1, 1'b1, -1};
      tbl[9]  = '{1'b1, 4'hF, 1'b1, 1'b1,  3};
      tbl[10] = '{1'b1, 4'hF, 1'b1, 1'b1, -1};
      tbl[11] = '{1'b1, 4'hF, 1'b1, 1'b1,  0};
      tbl[12] = '{1'b1, 4'h0, 1'b0, 1'b0, -1};

      drive(1'b0, 4'h0, 1'b0, 1'b0);

      for (int t = 0; t < 13; t++) begin
         step(tbl[t].rstn, tbl[t].vld, tbl[t].rdy, tbl[t].lst, tbl[t].exp, $sformatf("rr_tbl%0d", t));
      end

      // reset while master 2 requests, grant one cycle after release
      step(1'b0, 4'b0100, 1'b0, 1'b0, -1, "t1_rst_a");
      step(1'b0, 4'b0100, 1'b0, 1'b0, -1, "t1_rst_b");
      step(1'b1, 4'b0100, 1'b0, 1'b0, -1, "t1_release");
      step(1'b1, 4'b0100, 1'b0, 1'b0,  2, "t1_grant2");

      // 4-beat read on master 2
      rdy_cnt = 0; lst_cnt = 0;
      for (int b = 0; b < 4; b++) begin
         step(1'b1, 4'b0100, 1'b1, (b == 3), 2, $sformatf("t2_beat%0d", b));
         rdy_cnt += int'(iresps_s[2].ready);
         lst_cnt += int'(iresps_s[2].last);
      end
      check_val("t2_ready_beats", rdy_cnt, 4);
      check_val("t2_last_beats", lst_cnt, 1);
      step(1'b1, 4'hF, 1'b0, 1'b0, -1, "t2_idle");
      step(1'b1, 4'hF, 1'b1, 1'b1,  3, "t2_ptr3");
      step(1'b1, 4'h0, 1'b0, 1'b0, -1, "t2_done");

      // master 0 arrives during master 1's burst and waits for its last beat
      step(1'b1, 4'b0010, 1'b0, 1'b0, -1, "t4_req");
      step(1'b1, 4'b0010, 1'b1, 1'b0,  1, "t4_beat0");
      step(1'b1, 4'b0011, 1'b1, 1'b0,  1, "t4_m0_wait_a");
      step(1'b1, 4'b0011, 1'b1, 1'b0,  1, "t4_m0_wait_b");
      step(1'b1, 4'b0011, 1'b1, 1'b1,  1, "t4_last");
      step(1'b1, 4'b0011, 1'b0, 1'b0, -1, "t4_gap");
      step(1'b1, 4'b0011, 1'b1, 1'b1,  0, "t4_m0_grant");
      step(1'b1, 4'h0,    1'b0, 1'b0, -1, "t4_done");

      // master 3 withdraws after one beat
      step(1'b1, 4'b1000, 1'b1, 1'b0, -1, "t5_req");
      step(1'b1, 4'b1000, 1'b1, 1'b0,  3, "t5_beat1");
      step(1'b1, 4'b0000, 1'b1, 1'b0,  3, "t5_withdraw");
      step(1'b1, 4'b0000, 1'b1, 1'b0, -1, "t5_idle");
      step(1'b1, 4'b1001, 1'b0, 1'b0, -1, "t5_req2");
      step(1'b1, 4'b1001, 1'b1, 1'b1,  0, "t5_ptr0");
      step(1'b1, 4'h0,    1'b0, 1'b0, -1, "t5_done");

      // reset in the middle of a burst
      step(1'b1, 4'b0100, 1'b0, 1'b0, -1, "t6_req");
      step(1'b1, 4'b0100, 1'b1, 1'b0,  2, "t6_beat0");
      step(1'b1, 4'b0100, 1'b1, 1'b0,  2, "t6_beat1");
      step(1'b0, 4'b0100, 1'b1, 1'b0,  2, "t6_rst_assert");
      step(1'b0, 4'b0100, 1'b1, 1'b0, -1, "t6_rst_idle");
      step(1'b1, 4'b0011, 1'b0, 1'b0, -1, "t6_release");
      step(1'b1, 4'b0011, 1'b1, 1'b1,  0, "t6_ptr0");
      step(1'b1, 4'b0010, 1'b0, 1'b0, -1, "t6_gap");
      step(1'b1, 4'b0010, 1'b1, 1'b1,  1, "t6_m1");
      step(1'b1, 4'h0,    1'b0, 1'b0, -1, "t6_done");

      // randomized traffic against the reference model
      m_busy = 0; m_sel = 0; m_ptr = 0;
      for (int c = 0; c < 600; c++) begin
         logic         r_rstn;
         logic [N-1:0] r_vld;
         logic         r_rdy;
         logic         r_lst;
         int           exp;
         r_rstn = (c < 2) ? 1'b0 : ($urandom_range(0, 39) != 0);
         for (int i = 0; i < N; i++) r_vld[i] = ($urandom_range(0, 7) != 0);
         r_rdy = 1'($urandom_range(0, 1));
         r_lst = ($urandom_range(0, 2) == 0);
         exp   = (m_busy != 0) ? m_sel : -1;
         step(r_rstn, r_vld, r_rdy, r_lst, exp, "rand");
         model_update(r_rstn, r_vld, r_rdy, r_lst);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
